key_expansion: RTL and testbench
================================

# key_expansion

Iterative AES-128 key schedule that sits directly upstream of the `add_key` round stage. It accepts a 128-bit cipher key and produces one round key per clock until all 11 round keys (rounds 0..10) are stored in an internal register file. It then exposes the keys through a registered random-access read port, so the round datapath can fetch the key for any round.

## Interface
Parameters:
- None. AES-128 only: Nk=4, Nr=10, 11 round keys.

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  one clock; reset is synchronous and active-low.
- `key_valid`  input  1  request to load `key` and start expansion.
- `key`  input  128  cipher key; `key[127:120]` is byte 0 (FIPS-197 order), `w0 = key[127:96]`.
- `busy`  output  1  high while expansion is in progress.
- `done`  output  1  high when all 11 round keys are valid; a level, not a pulse.
- `rd_round`  input  4  round index to read, 0..10.
- `rd_key`  output  128  round key for `rd_round`; registered.

## Operation
- FSM states: IDLE, EXPAND, READY.
  - IDLE --`key_valid`--> EXPAND.
  - EXPAND --(round counter == 10 written)--> READY.
  - READY --`key_valid`--> EXPAND (restart).
  - EXPAND ignores `key_valid`.
- Accept edge, taken when `key_valid`=1 in IDLE or READY:
  - `rk[0] <= key`, `cnt <= 1`, `busy <= 1`, `done <= 0`.
  - `key` is sampled only on this edge; it may change afterwards.
- Each EXPAND edge:
  - `rk[cnt] <= next(rk[cnt-1], rcon[cnt])`, then `cnt <= cnt+1`.
  - On the edge writing `rk[10]`: `busy <= 0`, `done <= 1`, state goes to READY.
- `next(prev, rc)` for prev = {w0,w1,w2,w3}:
  - `t = SubWord(RotWord(w3)) ^ {rc, 24'h0}`. RotWord maps {b0,b1,b2,b3} to {b1,b2,b3,b0}.
  - `n0 = w0^t`, `n1 = w1^n0`, `n2 = w2^n1`, `n3 = w3^n2`.
- SubWord uses 4 parallel combinational byte lookups into the FIPS-197 forward S-box, held as an internal 256-entry table. The existing 128-bit registered `sbox` stage is not reused, because its latency breaks the one-key-per-cycle rate.
- `rcon[1..10]` = 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36. The value is selected by `cnt`; no multiplier.
- `cnt` is 4 bits and never exceeds 10. It holds its value in READY and IDLE.
- Read port, every cycle: `rd_key <= (rd_round <= 10) ? rk[rd_round] : 128'h0`.
- Reads during EXPAND return the current array contents. Entries not yet rewritten are stale, and this is not an error.
- Storage is 11 × 128 flops, no reset. Contents after reset are undefined until the first expansion completes.

## Timing
- Reset (`rst`=0 at an edge):
  - Outputs: `busy`=0, `done`=0, `rd_key`=0.
  - Internal: state=IDLE, `cnt`=0.
  - Reset mid-EXPAND aborts the expansion. `done` stays 0 until a new full expansion completes.
- Latency: accept at edge E0, `rk[n]` written at edge En, `done`=1 after E10.
  - `busy` is high for exactly 10 cycles (after E0 through E9).
- Throughput: one expansion per 11 cycles with `key_valid` held high continuously.
  - Restart from READY happens on the next edge; `done` is low for 10 cycles.
- Read latency: 1 cycle from `rd_round` to `rd_key`.
  - A read of round n issued in the cycle after En returns the new `rk[n]`.
- Simultaneous `rst`=0 and `key_valid`=1: reset wins.
- `key_valid` during EXPAND: no effect. The key is not queued.

## Test plan
- FIPS-197 A.1 key `2b7e151628aed2a6abf7158809cf4f3c`:
  - `done` rises exactly 10 cycles after the accept edge.
  - `rd_round`=1 → `a0fafe1788542cb123a339392a6c7605`.
  - `rd_round`=10 → `d014f9a8c9ee2589e13f0cc8b6630ca6`.
  - `rd_round`=0 → the key itself.
- All-zero key:
  - round 1 = `62636363626363636263636362636363`.
  - round 10 = `b4ef5bcb3e92e21123e951cf6f8f188e`.
- Back-to-back reload: A.1 key, then zero key accepted in READY.
  - `done` drops on the accept edge.
  - `busy` is high for 10 cycles.
  - Final round 10 = `b4ef5bcb3e92e21123e951cf6f8f188e`.
- `key_valid` pulsed with a different key at the 5th EXPAND cycle → ignored; the A.1 results are unchanged.
- `rst`=0 at the 4th EXPAND cycle:
  - Next cycle: `busy`=0, `done`=0, `rd_key`=0.
  - `done` stays 0 while `key_valid`=0.
  - A new A.1 load then completes correctly.
- `rd_round`=11 and `rd_round`=15 → `rd_key` = 0 one cycle later.
- `rd_round` sweep 0..10 in consecutive cycles → each key appears exactly one cycle after its index.

Source files
------------

// File: rtl/key_expansion.sv
// Iterative AES-128 key schedule: one round key per cycle into an 11-entry key file; done 10 cycles after accept.
// Registered read port (1-cycle latency); key_valid is ignored, not queued, while expansion is running.
module key_expansion (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  input  logic [127:0] key,
  output logic         busy,
  output logic         done,
  input  logic [3:0]   rd_round,
  output logic [127:0] rd_key
);

  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] prev, input logic [7:0] rc);
    logic [31:0] w3_rot;
    logic [31:0] t;
    logic [31:0] n0, n1, n2, n3;
    w3_rot = {prev[23:0], prev[31:24]};
    t  = {SBOX[w3_rot[31:24]], SBOX[w3_rot[23:16]], SBOX[w3_rot[15:8]], SBOX[w3_rot[7:0]]}
         ^ {rc, 24'h0};
    n0 = prev[127:96] ^ t;
    n1 = prev[95:64]  ^ n0;
    n2 = prev[63:32]  ^ n1;
    n3 = prev[31:0]   ^ n2;
    next_key = {n0, n1, n2, n3};
  endfunction

  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [127:0]   rd_key_q, rd_key_d;
  logic [127:0]   rk_q [0:10];

  logic           wr_en;
  logic [3:0]     wr_idx;
  logic [127:0]   wr_dat;
  logic [3:0]     prev_idx;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = done_q;
    prev_idx = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
    wr_en    = 1'b0;
    wr_idx   = cnt_q;
    wr_dat   = next_key(rk_q[prev_idx], rcon(cnt_q));
    rd_key_d = (rd_round <= 4'd10) ? rk_q[rd_round] : 128'h0;

    case (state_q)
      IDLE, READY: begin
        if (key_valid) begin
          state_d = EXPAND;
          cnt_d   = 4'd1;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          wr_en   = 1'b1;
          wr_idx  = 4'd0;
          wr_dat  = key;
        end
      end
      EXPAND: begin
        wr_en = 1'b1;
        // cnt saturates at 10 so it never points past the last key
        if (cnt_q == 4'd10) begin
          state_d = READY;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_key_q <= 128'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rd_key_q <= rd_key_d;
    end
  end

  // Key file carries no reset; writes are suppressed on a reset edge
  always_ff @(posedge clk) begin
    if (rst && wr_en) begin
      rk_q[wr_idx] <= wr_dat;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign rd_key = rd_key_q;

endmodule

// File: tb/tb_key_expansion.sv
// Bench for key_expansion: reference model builds the S-box from GF(2^8) inversion and runs the FIPS word recurrence.
module tb_key_expansion;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         key_valid = 1'b0;
  logic [127:0] key = 128'h0;
  logic         busy;
  logic         done;
  logic [3:0]   rd_round = 4'd0;
  logic [127:0] rd_key;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]   sb [256];
  logic [127:0] exp_rk [11];

  localparam logic [127:0] KEY_A1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  key_expansion dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key(key),
    .busy(busy), .done(done), .rd_round(rd_round), .rd_key(rd_key)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] xtime(input logic [7:0] v);
    xtime = {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = y >> 1;
    end
    gmul = p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    rotl8 = (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, av, bv;
    for (int a = 0; a < 256; a++) begin
      av  = a[7:0];
      inv = 8'h00;
      for (int b = 1; b < 256; b++) begin
        bv = b[7:0];
        if (gmul(av, bv) == 8'h01) inv = bv;
      end
      sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic model_expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] rand128();
    rand128 = {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [127:0] k);
    key = k;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    key = rand128();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    key_valid = 1'b1;
    key = KEY_A1;
    tick();
    tick();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_tests++; if (rd_key !== 128'h0) begin n_fail++; $display("FAIL reset_rd_key got %h want 0", rd_key); end
    rst = 1'b1;
    key_valid = 1'b0;
    tick();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy got %b want 0", busy); end
  endtask

  task automatic test_fips_a1();
    model_expand(KEY_A1);
    load(KEY_A1);
    n_tests++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL a1_accept busy/done got %b/%b want 1/0", busy, done); end
    for (int i = 1; i <= 10; i++) begin
      tick();
      n_tests++;
      if (done !== (i == 10) || busy !== (i < 10)) begin
        n_fail++; $display("FAIL a1_timing edge %0d busy/done got %b/%b want %b/%b", i, busy, done, i < 10, i == 10);
      end
    end
    rd_round = 4'd1; tick();
    n_tests++; if (rd_key !== 128'ha0fafe1788542cb123a339392a6c7605) begin n_fail++; $display("FAIL a1_round1 got %h", rd_key); end
    rd_round = 4'd10; tick();
    n_tests++; if (rd_key !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin n_fail++; $display("FAIL a1_round10 got %h", rd_key); end
    rd_round = 4'd0; tick();
    n_tests++; if (rd_key !== KEY_A1) begin n_fail++; $display("FAIL a1_round0 got %h want %h", rd_key, KEY_A1); end
  endtask

  task automatic test_zero_key();
    load(128'h0);
    for (int i = 1; i <= 10; i++) tick();
    n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL zero_done got %b want 1", done); end
    rd_round = 4'd1; tick();
    n_tests++; if (rd_key !== 128'h62636363626363636263636362636363) begin n_fail++; $display("FAIL zero_round1 got %h", rd_key); end
    rd_round = 4'd10; tick();
    n_tests++; if (rd_key !== 128'hb4ef5bcb3e92e21123e951cf6f8f188e) begin n_fail++; $display("FAIL zero_round10 got %h", rd_key); end
  endtask

  task automatic test_random_keys();
    logic [127:0] k;
    for (int n = 0; n < 4; n++) begin
      k = rand128();
      model_expand(k);
      load(k);
      for (int i = 1; i <= 10; i++) tick();
      for (int r = 0; r <= 10; r++) begin
        rd_round = r[3:0];
        tick();
        n_tests++;
        if (rd_key !== exp_rk[r]) begin
          n_fail++; $display("FAIL random_key%0d round%0d got %h want %h", n, r, rd_key, exp_rk[r]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int busy_cycles;
    load(KEY_A1);
    for (int i = 1; i <= 10; i++) tick();
    key = 128'h0;
    key_valid = 1'b1;
    tick();
    key = rand128();
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL b2b_done_drop got %b want 0", done); end
    busy_cycles = (busy === 1'b1) ? 1 : 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (busy === 1'b1) busy_cycles++;
    end
    key_valid = 1'b0;
    n_tests++; if (busy_cycles != 10) begin n_fail++; $display("FAIL b2b_busy_cycles got %0d want 10", busy_cycles); end
    n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_done got %b want 1", done); end
    rd_round = 4'd10; tick();
    n_tests++; if (rd_key !== 128'hb4ef5bcb3e92e21123e951cf6f8f188e) begin n_fail++; $display("FAIL b2b_round10 got %h", rd_key); end
  endtask

  task automatic test_ignore_valid();
    model_expand(KEY_A1);
    load(KEY_A1);
    for (int i = 1; i <= 4; i++) tick();
    key = rand128();
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    for (int i = 6; i <= 10; i++) tick();
    n_tests++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL ignore_done busy/done got %b/%b want 0/1", busy, done); end
    for (int r = 0; r <= 10; r++) begin
      rd_round = r[3:0];
      tick();
      n_tests++;
      if (rd_key !== exp_rk[r]) begin
        n_fail++; $display("FAIL ignore_round%0d got %h want %h", r, rd_key, exp_rk[r]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int done_seen;
    rd_round = 4'd3;
    load(KEY_A1);
    for (int i = 1; i <= 3; i++) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL midrst_done got %b want 0", done); end
    n_tests++; if (rd_key !== 128'h0) begin n_fail++; $display("FAIL midrst_rd_key got %h want 0", rd_key); end
    done_seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done !== 1'b0) done_seen++;
    end
    n_tests++; if (done_seen != 0) begin n_fail++; $display("FAIL midrst_done_stays_low got %0d high cycles want 0", done_seen); end
    model_expand(KEY_A1);
    load(KEY_A1);
    for (int i = 1; i <= 10; i++) tick();
    n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL midrst_reload_done got %b want 1", done); end
    rd_round = 4'd10; tick();
    n_tests++; if (rd_key !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin n_fail++; $display("FAIL midrst_round10 got %h", rd_key); end
  endtask

  task automatic test_read_sweep();
    for (int r = 0; r <= 10; r++) begin
      rd_round = r[3:0];
      tick();
      n_tests++;
      if (rd_key !== exp_rk[r]) begin
        n_fail++; $display("FAIL sweep_round%0d got %h want %h", r, rd_key, exp_rk[r]);
      end
    end
  endtask

  task automatic test_out_of_range();
    rd_round = 4'd10; tick();
    rd_round = 4'd11; tick();
    n_tests++; if (rd_key !== 128'h0) begin n_fail++; $display("FAIL oor_round11 got %h want 0", rd_key); end
    rd_round = 4'd5; tick();
    n_tests++; if (rd_key !== exp_rk[5]) begin n_fail++; $display("FAIL oor_round5 got %h want %h", rd_key, exp_rk[5]); end
    rd_round = 4'd15; tick();
    n_tests++; if (rd_key !== 128'h0) begin n_fail++; $display("FAIL oor_round15 got %h want 0", rd_key); end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_fips_a1();
    test_zero_key();
    test_random_keys();
    test_back_to_back();
    test_ignore_valid();
    test_reset_mid();
    test_read_sweep();
    test_out_of_range();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
